// File: rtl/ccsds123_bit_unpacker.sv
// Bit-field reader for the CCSDS-123 packed stream: byte-ordered AXI words in, MSB-first fields out.
// Optional lookahead port enabled by defining CCSDS123_UNPACK_PEEK_EN.
`timescale 1ns/1ps

module ccsds123_bit_unpacker #(
  parameter int BUS_WIDTH = 64,
  parameter int MAX_LEN   = 32,
  parameter int LEN_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] in_tdata,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic                 in_tlast,
  input  logic [LEN_W-1:0]     fld_len,
  input  logic                 fld_valid,
  output logic                 fld_ready,
  input  logic                 flush,
  output logic [MAX_LEN-1:0]   res_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_underrun,
  output logic                 res_last
`ifdef CCSDS123_UNPACK_PEEK_EN
  ,
  output logic [MAX_LEN-1:0]   peek_data,
  output logic [LEN_W-1:0]     peek_cnt
`endif
);

  localparam int BUF_W = 2 * BUS_WIDTH;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [CNT_W-1:0] BW_C = CNT_W'(BUS_WIDTH);
  localparam logic [CNT_W-1:0] ML_C = CNT_W'(MAX_LEN);

  typedef enum logic [1:0] {RUN, TAIL, SKIP} state_t;

  state_t           state;
  logic [BUF_W-1:0] buffer;
  logic [CNT_W-1:0] cnt;

  logic                 word_acc;
  logic                 fld_acc;
  logic [BUS_WIDTH-1:0] rev;
  logic [CNT_W-1:0]     len_ext;
  logic [CNT_W-1:0]     consumed;
  logic [CNT_W-1:0]     cnt_left;
  logic [BUF_W-1:0]     buf_shift;
  logic [BUF_W-1:0]     buf_load;
  logic [MAX_LEN-1:0]   top;
  logic [LEN_W-1:0]     drop;

  // Byte 0 goes to the top so the buffer MSB is always the next stream bit.
  for (genvar k = 0; k < BUS_WIDTH / 8; k++) begin : g_rev
    assign rev[BUS_WIDTH-1-8*k -: 8] = in_tdata[8*k +: 8];
  end

  assign in_tready = (state == SKIP) || ((state == RUN) && (cnt <= BW_C));
  assign word_acc  = in_tvalid && in_tready;

  always_comb begin
    fld_ready = 1'b0;
    if (!flush && (!res_valid || res_ready)) begin
      if (state == RUN)
        fld_ready = (cnt >= ML_C);
      else if (state == TAIL)
        fld_ready = (cnt != '0);
    end
  end

  assign fld_acc   = fld_valid && fld_ready;
  assign len_ext   = CNT_W'(fld_len);
  assign consumed  = fld_acc ? ((len_ext < cnt) ? len_ext : cnt) : '0;
  assign cnt_left  = cnt - consumed;
  assign buf_shift = buffer << consumed;
  assign buf_load  = {rev, {BUS_WIDTH{1'b0}}} >> cnt_left;

  // Bits past cnt are kept zero, so a short tail field is zero-filled for free.
  assign top  = buffer[BUF_W-1 -: MAX_LEN];
  assign drop = LEN_W'(MAX_LEN) - fld_len;

`ifdef CCSDS123_UNPACK_PEEK_EN
  assign peek_data = top;
  assign peek_cnt  = (cnt >= ML_C) ? LEN_W'(MAX_LEN) : LEN_W'(cnt);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= '0;
      buffer       <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_underrun <= 1'b0;
      res_last     <= 1'b0;
    end else begin
      if (fld_acc) begin
        res_valid    <= 1'b1;
        res_data     <= top >> drop;
        res_underrun <= (len_ext > cnt);
        res_last     <= (state == TAIL) && (cnt_left == '0);
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end

      if (flush && (state != SKIP)) begin
        cnt    <= '0;
        buffer <= '0;
        state  <= ((state == RUN) && !(word_acc && in_tlast)) ? SKIP : RUN;
      end else begin
        case (state)
          RUN: begin
            cnt    <= cnt_left + (word_acc ? BW_C : '0);
            buffer <= word_acc ? (buf_shift | buf_load) : buf_shift;
            if (word_acc && in_tlast)
              state <= TAIL;
          end
          TAIL: begin
            cnt    <= cnt_left;
            buffer <= buf_shift;
            if (cnt_left == '0)
              state <= RUN;
          end
          SKIP: begin
            cnt    <= '0;
            buffer <= '0;
            if (word_acc && in_tlast)
              state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  len_legal: assert property (@(posedge clk) disable iff (rst)
    (fld_valid && fld_ready) |-> ((fld_len != '0) && (fld_len <= LEN_W'(MAX_LEN))));

endmodule

// File: tb/tb_ccsds123_bit_unpacker.sv
// Self-checking bench for ccsds123_bit_unpacker: directed cases plus randomized streams
// checked against a bit-queue reference model.
`timescale 1ns/1ps

module tb_ccsds123_bit_unpacker;

  logic        clk;
  logic        rst;
  logic [63:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic        in_tlast;
  logic [5:0]  fld_len;
  logic        fld_valid;
  logic        fld_ready;
  logic        flush;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        res_underrun;
  logic        res_last;
`ifdef CCSDS123_UNPACK_PEEK_EN
  logic [31:0] peek_data;
  logic [5:0]  peek_cnt;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [31:0] data;
    logic        und;
    logic        lst;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] words[$];
  bit          lasts[$];
  int          stream_bits[$];
  bit          model_bits[$];
  bit          cons_done;

  ccsds123_bit_unpacker #(.BUS_WIDTH(64), .MAX_LEN(32), .LEN_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_tdata     (in_tdata),
    .in_tvalid    (in_tvalid),
    .in_tready    (in_tready),
    .in_tlast     (in_tlast),
    .fld_len      (fld_len),
    .fld_valid    (fld_valid),
    .fld_ready    (fld_ready),
    .flush        (flush),
    .res_data     (res_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_underrun (res_underrun),
    .res_last     (res_last)
`ifdef CCSDS123_UNPACK_PEEK_EN
    ,
    .peek_data    (peek_data),
    .peek_cnt     (peek_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic sendWord(input logic [63:0] data, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    in_tdata  = data;
    in_tlast  = last;
    in_tvalid = 1'b1;
    #1;
    while (!in_tready && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_tready) checkOutput("word_timeout", 0, 1);
    @(negedge clk);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic getField(input int len, output logic [31:0] data, output logic und, output logic lst);
    int guard;
    guard = 0;
    @(negedge clk);
    fld_len   = 6'(len);
    fld_valid = 1'b1;
    res_ready = 1'b1;
    #1;
    while (!fld_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!fld_ready) checkOutput("fld_timeout", 0, 1);
    @(negedge clk);
    fld_valid = 1'b0;
    checkOutput("res_valid_latency", res_valid, 1);
    data = res_data;
    und  = res_underrun;
    lst  = res_last;
  endtask

  // Random streams: the model is a flat queue of stream bits, fields are popped MSB-first.
  task automatic applyStimulus(input int n_streams);
    logic [63:0] w;
    int          nw;
    for (int s = 0; s < n_streams; s++) begin
      nw = $urandom_range(1, 4);
      for (int i = 0; i < nw; i++) begin
        w = {$urandom, $urandom};
        words.push_back(w);
        lasts.push_back(i == nw - 1);
        for (int k = 0; k < 8; k++)
          for (int b = 7; b >= 0; b--)
            model_bits.push_back(w[8*k + b]);
      end
      stream_bits.push_back(nw * 64);
    end
    cons_done = 1'b0;

    fork
      begin : prod_blk
        for (int i = 0; i < words.size(); i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          sendWord(words[i], lasts[i]);
        end
      end
      begin : cons_blk
        int          left;
        int          len;
        int          take;
        int          guard;
        logic [31:0] val;
        bit          b;
        bit          ok;
        exp_t        e;
        ok = 1'b1;
        for (int s = 0; s < stream_bits.size() && ok; s++) begin
          left = stream_bits[s];
          while (left > 0 && ok) begin
            len  = $urandom_range(1, 32);
            take = (len < left) ? len : left;
            val  = '0;
            for (int i = 0; i < len; i++) begin
              b = 1'b0;
              if (i < take) b = model_bits.pop_front();
              val = {val[30:0], b};
            end
            left  = left - take;
            e.data = val;
            e.und  = (len > take);
            e.lst  = (left == 0);
            repeat ($urandom_range(0, 1)) @(negedge clk);
            @(negedge clk);
            fld_len   = 6'(len);
            fld_valid = 1'b1;
            #2;
            guard = 0;
            while (!fld_ready && guard < 2000) begin
              @(negedge clk);
              #2;
              guard++;
            end
            if (!fld_ready) begin
              checkOutput("rand_fld_timeout", 0, 1);
              ok = 1'b0;
            end else begin
              exp_q.push_back(e);
            end
            @(negedge clk);
            fld_valid = 1'b0;
          end
        end
        cons_done = 1'b1;
      end
      begin : chk_blk
        int   cycles;
        exp_t e;
        cycles = 0;
        while ((!cons_done || exp_q.size() > 0) && cycles < 40000) begin
          @(negedge clk);
          res_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
              checkOutput("rand_unexpected_result", 1, 0);
            end else begin
              e = exp_q.pop_front();
              checkOutput("rand_data", res_data, e.data);
              checkOutput("rand_underrun", res_underrun, e.und);
              checkOutput("rand_last", res_last, e.lst);
            end
          end
          cycles++;
        end
        if (cycles >= 40000) checkOutput("rand_cycle_budget", 0, 1);
        res_ready = 1'b1;
      end
    join
  endtask

  initial begin
    logic [31:0] d;
    logic        u;
    logic        l;
    logic [63:0] w;

    rst       = 1'b1;
    in_tdata  = '0;
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    fld_len   = 6'd8;
    fld_valid = 1'b1;
    flush     = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_fld_ready", fld_ready, 0);
    checkOutput("rst_in_tready", in_tready, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_cnt_zero", fld_ready, 0);
    fld_valid = 1'b0;

    $display("[TB] single tlast word");
    sendWord(64'h0123456789ABCDEF, 1'b1);
    getField(8, d, u, l);  checkOutput("w_len8", d, 32'hEF);
    getField(4, d, u, l);  checkOutput("w_len4a", d, 32'hC);
    getField(4, d, u, l);  checkOutput("w_len4b", d, 32'hD);
    getField(32, d, u, l); checkOutput("w_len32", d, 32'hAB896745);
    checkOutput("w_len32_last", l, 0);
    getField(16, d, u, l); checkOutput("w_tail16", d, 32'h2301);
    checkOutput("w_tail16_last", l, 1);
    checkOutput("w_tail16_und", u, 0);
    #1;
    checkOutput("w_back_to_run", in_tready, 1);

    $display("[TB] cross-word field");
    sendWord(64'h0, 1'b0);
    getField(32, d, u, l); checkOutput("x_zero32", d, 32'h0);
    getField(16, d, u, l); checkOutput("x_zero16", d, 32'h0);
    sendWord(64'hFFFFFFFFFFFFFFFF, 1'b1);
    getField(32, d, u, l); checkOutput("x_straddle", d, 32'h0000FFFF);
    getField(32, d, u, l); checkOutput("x_ones32", d, 32'hFFFFFFFF);
    getField(16, d, u, l); checkOutput("x_ones16", d, 32'hFFFF);
    checkOutput("x_last", l, 1);

    $display("[TB] tail underrun");
    sendWord(64'hFFFFFFFFFFFFFFFF, 1'b1);
    getField(32, d, u, l);
    getField(16, d, u, l); checkOutput("u_pre_und", u, 0);
    getField(32, d, u, l); checkOutput("u_data", d, 32'hFFFF0000);
    checkOutput("u_underrun", u, 1);
    checkOutput("u_last", l, 1);
    #1;
    checkOutput("u_in_tready", in_tready, 1);

    $display("[TB] flush mid-stream");
    sendWord(64'h1122334455667788, 1'b0);
    getField(32, d, u, l); checkOutput("f_w0a", d, 32'h88776655);
    getField(32, d, u, l); checkOutput("f_w0b", d, 32'h44332211);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    w = {$urandom, $urandom};
    sendWord(w, 1'b0);
    #1;
    checkOutput("f_skip_fld_ready", fld_ready, 0);
    w = {$urandom, $urandom};
    sendWord(w, 1'b1);
    sendWord(64'hDEADBEEF1234565A, 1'b1);
    getField(8, d, u, l); checkOutput("f_next_stream", d, 32'h5A);
    @(negedge clk);
    fld_len = 6'd8; fld_valid = 1'b1; flush = 1'b1;
    #1;
    checkOutput("f_flush_beats_req", fld_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("f_tail_cleared", fld_ready, 0);
    checkOutput("f_tail_in_tready", in_tready, 1);
    fld_valid = 1'b0;

    $display("[TB] result backpressure");
    sendWord(64'h0123456789ABCDEF, 1'b1);
    @(negedge clk);
    res_ready = 1'b0; fld_len = 6'd8; fld_valid = 1'b1;
    #1;
    checkOutput("bp_first_ready", fld_ready, 1);
    @(negedge clk);
    #1;
    checkOutput("bp_first_data", res_data, 32'hEF);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_valid", res_valid, 1);
      checkOutput("bp_hold_data", res_data, 32'hEF);
      checkOutput("bp_hold_ready", fld_ready, 0);
      @(negedge clk);
      #1;
    end
    res_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", fld_ready, 1);
    @(negedge clk);
    fld_valid = 1'b0;
    #1;
    checkOutput("bp_next_valid", res_valid, 1);
    checkOutput("bp_next_data", res_data, 32'hCD);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    checkOutput("bp_flush_run", in_tready, 1);

    $display("[TB] reset with pending result");
    sendWord(64'h0123456789ABCDEF, 1'b1);
    @(negedge clk);
    res_ready = 1'b0; fld_len = 6'd8; fld_valid = 1'b1;
    @(negedge clk);
    fld_valid = 1'b0;
    #1;
    checkOutput("mr_pending", res_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fld_valid = 1'b1;
    #1;
    checkOutput("mr_res_valid", res_valid, 0);
    checkOutput("mr_fld_ready", fld_ready, 0);
    checkOutput("mr_in_tready", in_tready, 1);
    fld_valid = 1'b0;
    res_ready = 1'b1;

    $display("[TB] randomized streams");
    applyStimulus(25);
    repeat (5) @(negedge clk);
    checkOutput("rand_all_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
